// File: rtl/spectral_band_permuter_if.sv
// Bin-serial bus of the band permuter: natural-order frame in, band-permuted frame out.
// Slave is the permuter's view; master is the upstream/downstream view.
interface spectral_band_permuter_if #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 24,
  parameter int CNT_W  = 6
);
  logic              di_en;
  logic              di_sof;
  logic [DATA_W-1:0] di_re;
  logic [DATA_W-1:0] di_im;
  logic [KEY_W-1:0]  key;
  logic              mode;
  logic              do_en;
  logic              do_sof;
  logic [DATA_W-1:0] do_re;
  logic [DATA_W-1:0] do_im;
  logic [CNT_W-1:0]  do_count;
  logic              frame_drop;
  logic              key_err;

  modport master (
    output di_en, di_sof, di_re, di_im, key, mode,
    input  do_en, do_sof, do_re, do_im, do_count, frame_drop, key_err
  );

  modport slave (
    input  di_en, di_sof, di_re, di_im, key, mode,
    output do_en, do_sof, do_re, do_im, do_count, frame_drop, key_err
  );
endinterface

// File: rtl/spectral_band_permuter.sv
// Ping-pong band permuter: output bin 0 two cycles after last input bin, fixed-rate, no backpressure.
// SBP_KEY_CHECK_EN: non-permutation keys fall back to identity and raise key_err.
module spectral_band_permuter #(
  parameter  int DATA_W    = 16,
  parameter  int FRAME_LEN = 64,
  parameter  int BAND_LEN  = 8,
  localparam int NB        = FRAME_LEN / BAND_LEN,
  localparam int NBW       = $clog2(NB),
  localparam int KEY_W     = NB * NBW,
  localparam int CNT_W     = $clog2(FRAME_LEN),
  localparam int BLW       = $clog2(BAND_LEN)
) (
  input logic                    clock,
  input logic                    reset,
  spectral_band_permuter_if.slave bus
);

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FRAME_LEN - 1);

  rd_state_t          rd_state;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   wr_addr;
  logic               wr_bank;
  logic               resync;
  logic               wr_last;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   rd_addr;
  logic               rd_bank;
  logic [KEY_W-1:0]   key_q;
  logic               mode_q;
  logic               key_ok;
  logic [NBW-1:0]     rd_band;
  logic [NBW-1:0]     src_scr;
  logic [NBW-1:0]     src_dsc;
  logic [NBW-1:0]     src_band;
  logic [2*DATA_W-1:0] mem [2*FRAME_LEN];

  logic               do_en_q;
  logic               do_sof_q;
  logic [DATA_W-1:0]  do_re_q;
  logic [DATA_W-1:0]  do_im_q;
  logic [CNT_W-1:0]   do_count_q;
  logic               frame_drop_q;
  logic               key_err_q;

  // A mid-frame start-of-frame restarts the write side at bin 0 of the same bank.
  assign resync  = bus.di_en & bus.di_sof & (wr_cnt != '0);
  assign wr_addr = resync ? '0 : wr_cnt;
  assign wr_last = bus.di_en & (wr_addr == LAST_BIN);

  always_ff @(posedge clock) begin
    if (bus.di_en)
      mem[{wr_bank, wr_addr}] <= {bus.di_re, bus.di_im};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_cnt       <= '0;
      wr_bank      <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      frame_drop_q <= resync;
      if (bus.di_en) begin
        wr_cnt <= wr_addr + CNT_W'(1);
        if (wr_last)
          wr_bank <= ~wr_bank;
      end
    end
  end

`ifdef SBP_KEY_CHECK_EN
  logic [NB-1:0] seen;

  always_comb begin
    seen = '0;
    for (int i = 0; i < NB; i++)
      seen[key_q[NBW*i +: NBW]] = 1'b1;
    key_ok = &seen;
  end
`else
  assign key_ok = 1'b1;
`endif

  assign rd_band = rd_cnt[CNT_W-1 -: NBW];

  // Inverse lookup scans downward so the lowest matching field wins on a bad key.
  always_comb begin
    src_scr = key_q[NBW*int'(rd_band) +: NBW];
    src_dsc = rd_band;
    for (int i = NB - 1; i >= 0; i--)
      if (key_q[NBW*i +: NBW] == rd_band)
        src_dsc = NBW'(i);
    src_band = mode_q ? src_dsc : src_scr;
    if (!key_ok)
      src_band = rd_band;
  end

  assign rd_addr = (CNT_W'(src_band) << BLW) | (rd_cnt & CNT_W'(BAND_LEN - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state   <= RD_IDLE;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      do_en_q    <= 1'b0;
      do_sof_q   <= 1'b0;
      do_re_q    <= '0;
      do_im_q    <= '0;
      do_count_q <= '0;
      key_err_q  <= 1'b0;
    end else begin
      do_en_q  <= 1'b0;
      do_sof_q <= 1'b0;
      if (rd_state == RD_RUN) begin
        do_en_q              <= 1'b1;
        do_sof_q             <= (rd_cnt == '0);
        do_count_q           <= rd_cnt;
        {do_re_q, do_im_q}   <= mem[{rd_bank, rd_addr}];
        if (rd_cnt == '0)
          key_err_q <= ~key_ok;
        rd_cnt <= rd_cnt + CNT_W'(1);
        if (rd_cnt == LAST_BIN)
          rd_state <= RD_IDLE;
      end else begin
        do_count_q <= '0;
      end
      // A completion on the last address cycle chains straight into the next burst.
      if (wr_last) begin
        rd_state <= RD_RUN;
        rd_cnt   <= '0;
        rd_bank  <= wr_bank;
        key_q    <= bus.key;
        mode_q   <= bus.mode;
      end
    end
  end

  assign bus.do_en      = do_en_q;
  assign bus.do_sof     = do_sof_q;
  assign bus.do_re      = do_re_q;
  assign bus.do_im      = do_im_q;
  assign bus.do_count   = do_count_q;
  assign bus.frame_drop = frame_drop_q;
  assign bus.key_err    = key_err_q;

endmodule

// File: tb/tb_spectral_band_permuter.sv
// Directed bench for spectral_band_permuter at the default 64-bin / 8-band configuration.
module tb_spectral_band_permuter;
  localparam int DATA_W = 16;
  localparam int KEY_W  = 24;
  localparam int CNT_W  = 6;
  localparam logic [23:0] K_ID  = 24'hFAC688;
  localparam logic [23:0] K_REV = 24'h053977;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spectral_band_permuter_if #(.DATA_W(DATA_W), .KEY_W(KEY_W), .CNT_W(CNT_W)) bus ();

  spectral_band_permuter #(.DATA_W(DATA_W), .FRAME_LEN(64), .BAND_LEN(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int drop_cnt = 0;

  logic [15:0] out_re[$];
  logic [15:0] out_im[$];
  int          out_cnt[$];
  bit          out_sof[$];
  int          out_cyc[$];

  logic [15:0] orig_re[64], orig_im[64];
  logic [15:0] in_re[64],   in_im[64];
  logic [15:0] exp_re[64],  exp_im[64];
  logic [23:0] k_rot;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.do_en) begin
      out_re.push_back(bus.do_re);
      out_im.push_back(bus.do_im);
      out_cnt.push_back(int'(bus.do_count));
      out_sof.push_back(bus.do_sof);
      out_cyc.push_back(cyc);
    end
    if (bus.frame_drop) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic clear_out();
    out_re.delete(); out_im.delete(); out_cnt.delete(); out_sof.delete(); out_cyc.delete();
  endtask

  // Drives in_re/in_im as one frame; gap_at inserts a di_sof-without-di_en cycle before that bin.
  task automatic drive_frame(input logic [23:0] k, input logic m, input int gap_at, output int last_cyc);
    for (int i = 0; i < 64; i++) begin
      if (i == gap_at) begin
        bus.di_en = 1'b0; bus.di_sof = 1'b1;
        @(posedge clock); #1;
        bus.di_sof = 1'b0;
      end
      bus.di_en  = 1'b1;
      bus.di_sof = (i == 0);
      bus.di_re  = in_re[i];
      bus.di_im  = in_im[i];
      bus.key    = k;
      bus.mode   = m;
      last_cyc   = cyc;
      @(posedge clock); #1;
    end
    bus.di_en  = 1'b0;
    bus.di_sof = 1'b0;
    bus.key    = ~k;
    bus.mode   = ~m;
  endtask

  task automatic wait_out(input int n, input string tag);
    int b = 0;
    while (out_re.size() < n && b < 400) begin
      @(negedge clock);
      b++;
    end
    #1;
    check({tag, " count"}, out_re.size(), n);
  endtask

  task automatic check_burst(input string tag, input int off, input int last_in);
    if (out_re.size() < off + 64) begin
      check({tag, " short"}, out_re.size(), off + 64);
      return;
    end
    check({tag, " latency"}, out_cyc[off] - last_in, 2);
    check({tag, " contiguous"}, out_cyc[off+63] - out_cyc[off], 63);
    for (int k = 0; k < 64; k++) begin
      check($sformatf("%s re[%0d]", tag, k),  out_re[off+k],  exp_re[k]);
      check($sformatf("%s im[%0d]", tag, k),  out_im[off+k],  exp_im[k]);
      check($sformatf("%s cnt[%0d]", tag, k), out_cnt[off+k], k);
      check($sformatf("%s sof[%0d]", tag, k), out_sof[off+k], (k == 0));
    end
  endtask

  task automatic set_exp_band(input int shift, input bit band0_only);
    for (int k = 0; k < 64; k++) begin
      int s;
      s = band0_only ? (k % 8) : ((((k / 8) + shift) % 8) * 8 + (k % 8));
      exp_re[k] = orig_re[s];
      exp_im[k] = orig_im[s];
    end
  endtask

  task automatic set_exp_rev();
    for (int k = 0; k < 64; k++) begin
      exp_re[k] = orig_re[(7 - k / 8) * 8 + k % 8];
      exp_im[k] = orig_im[(7 - k / 8) * 8 + k % 8];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int la, lb, lc;
    bit found;
    logic [31:0] exp_err;

    bus.di_en = 1'b0; bus.di_sof = 1'b0; bus.di_re = '0; bus.di_im = '0;
    bus.key = '0; bus.mode = 1'b0;
    for (int i = 0; i < 64; i++) begin
      orig_re[i] = 16'(i);
      orig_im[i] = 16'h4000 + 16'(i * 5);
      in_re[i]   = orig_re[i];
      in_im[i]   = orig_im[i];
    end
    k_rot = '0;
    for (int j = 0; j < 8; j++) k_rot |= 24'((j + 1) % 8) << (3 * j);

    #2 reset = 1'b0;
    #10;
    check("rst do_en", bus.do_en, 0);
    check("rst do_sof", bus.do_sof, 0);
    check("rst do_count", bus.do_count, 0);
    check("rst do_re", bus.do_re, 0);
    check("rst do_im", bus.do_im, 0);
    check("rst frame_drop", bus.frame_drop, 0);
    check("rst key_err", bus.key_err, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // Identity then reversal, back to back.
    clear_out();
    drive_frame(K_ID, 1'b0, -1, la);
    drive_frame(K_REV, 1'b0, -1, lb);
    wait_out(128, "b2b");
    set_exp_band(0, 1'b0);
    check_burst("ident", 0, la);
    set_exp_rev();
    check_burst("rev", 64, lb);
    check("key_err valid", bus.key_err, 0);

    // Reversal round trip: scrambled output fed back in descramble mode.
    for (int k = 0; k < 64; k++) begin in_re[k] = out_re[64+k]; in_im[k] = out_im[64+k]; end
    clear_out();
    drive_frame(K_REV, 1'b1, -1, lc);
    wait_out(64, "rev rt");
    set_exp_band(0, 1'b0);
    check_burst("rev rt", 0, lc);

    // Rotation key is not self-inverse, so it separates scramble from descramble.
    for (int k = 0; k < 64; k++) begin in_re[k] = orig_re[k]; in_im[k] = orig_im[k]; end
    clear_out();
    drive_frame(k_rot, 1'b0, -1, la);
    wait_out(64, "rot");
    set_exp_band(1, 1'b0);
    check_burst("rot", 0, la);
    for (int k = 0; k < 64; k++) begin in_re[k] = out_re[k]; in_im[k] = out_im[k]; end
    clear_out();
    drive_frame(k_rot, 1'b1, -1, lb);
    wait_out(64, "rot rt");
    set_exp_band(0, 1'b0);
    check_burst("rot rt", 0, lb);
    check("no drop yet", drop_cnt, 0);

    // Resync: 20-bin partial frame, then a full frame whose sof lands at wr_cnt 20.
    for (int k = 0; k < 64; k++) begin in_re[k] = orig_re[k]; in_im[k] = orig_im[k]; end
    clear_out();
    for (int i = 0; i < 20; i++) begin
      bus.di_en = 1'b1; bus.di_sof = (i == 0);
      bus.di_re = 16'(900 + i); bus.di_im = 16'(1900 + i);
      @(posedge clock); #1;
    end
    bus.di_en = 1'b0; bus.di_sof = 1'b0;
    repeat (4) @(posedge clock); #1;
    check("partial no output", out_re.size(), 0);
    check("partial no drop", drop_cnt, 0);
    drive_frame(K_ID, 1'b0, 30, lc);
    wait_out(64, "resync");
    repeat (5) @(negedge clock); #1;
    check("resync exact len", out_re.size(), 64);
    check("resync drop", drop_cnt, 1);
    check_burst("resync", 0, lc);

    // All-zero key: only band 0 repeated unless the key check substitutes identity.
    clear_out();
    drive_frame(24'h000000, 1'b0, -1, la);
    wait_out(64, "key0");
`ifdef SBP_KEY_CHECK_EN
    set_exp_band(0, 1'b0);
    exp_err = 1;
`else
    set_exp_band(0, 1'b1);
    exp_err = 0;
`endif
    check_burst("key0", 0, la);
    check("key0 key_err", bus.key_err, exp_err);

    clear_out();
    drive_frame(24'h000000, 1'b1, -1, lb);
    wait_out(64, "key0 dsc");
    set_exp_band(0, 1'b0);
    check_burst("key0 dsc", 0, lb);
    check("key0 dsc key_err", bus.key_err, exp_err);

    // Reset in the middle of a burst.
    clear_out();
    drive_frame(K_REV, 1'b0, -1, la);
    found = 1'b0;
    for (int b = 0; b < 200 && !found; b++) begin
      @(negedge clock);
      if (bus.do_en && bus.do_count == 30) found = 1'b1;
    end
    check("reach cnt30", found, 1);
    #2 reset = 1'b0;
    #1;
    check("mid rst do_en", bus.do_en, 0);
    check("mid rst do_count", bus.do_count, 0);
    check("mid rst key_err", bus.key_err, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    clear_out();
    repeat (10) @(negedge clock); #1;
    check("post rst silent", out_re.size(), 0);
    drive_frame(K_REV, 1'b0, -1, lb);
    wait_out(64, "post rst");
    set_exp_rev();
    check_burst("post rst", 0, lb);
    check("post rst key_err", bus.key_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
